// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern-mode controller: mode encodings,
// controller state type and default timing parameters.
package vga_pkg;

    localparam logic [1:0] MODE_HBARS = 2'd0;
    localparam logic [1:0] MODE_VBARS = 2'd1;
    localparam logic [1:0] MODE_XOR   = 2'd2;
    localparam logic [1:0] MODE_XNOR  = 2'd3;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_AUTO_FRAMES     = 120;

    // Wide enough for the largest legal AUTO_FRAMES (4095).
    localparam int FCNT_W = 12;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// One raw active-low push button: 2-flop synchronizer, stable-count debounce,
// and a one-cycle press pulse on each debounced 1->0 transition.
module btn_debounce
    import vga_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          db_q, db_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            db_q      <= 1'b1;
            db_prev_q <= 1'b1;
            press_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
            if (s2_q == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                db_q  <= ~db_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Edge detect one cycle behind the debounced level; releases give nothing.
            db_prev_q <= db_q;
            press_q   <= db_prev_q & ~db_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/vga_mode_ctrl.sv
// Pattern-mode controller: next/prev buttons and an auto-cycle timer step a
// pending mode, which is committed to key on each vsync falling edge.
module vga_mode_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned AUTO_FRAMES     = DEF_AUTO_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_auto,
    input  logic       vsync,
    output logic [1:0] key,
    output logic       auto_on,
    output logic       mode_changed
);
    localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(AUTO_FRAMES - 1);

    logic              press_next, press_prev, press_auto;
    logic              vs1_q, vs2_q, vs3_q, frame_tick;
    logic              auto_step, manual_step;
    state_t            state_q, state_d;
    logic [1:0]        pending_q, pending_d, key_q;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              mode_changed_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(clk), .rst(rst), .btn_i(btn_next), .press_o(press_next));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk(clk), .rst(rst), .btn_i(btn_prev), .press_o(press_prev));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_auto (
        .clk(clk), .rst(rst), .btn_i(btn_auto), .press_o(press_auto));

    assign frame_tick  = vs3_q & ~vs2_q;
    assign manual_step = press_next | press_prev;
    // A mode toggle on the wrap frame clears the counter and suppresses the step.
    assign auto_step   = (state_q == AUTO) && frame_tick && (fcnt_q == FRAME_LAST) && !press_auto;

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        pending_d = pending_q;
        if (press_auto) begin
            state_d = (state_q == AUTO) ? MANUAL : AUTO;
            fcnt_d  = '0;
        end else if ((state_q == AUTO) && frame_tick) begin
            fcnt_d = (fcnt_q == FRAME_LAST) ? '0 : fcnt_q + 1'b1;
        end
        if (manual_step) begin
            fcnt_d = '0;
            if (press_next && !press_prev)
                pending_d = pending_q + 2'd1;
            else if (press_prev && !press_next)
                pending_d = pending_q - 2'd1;
        end else if (auto_step) begin
            pending_d = pending_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs1_q          <= 1'b1;
            vs2_q          <= 1'b1;
            vs3_q          <= 1'b1;
            state_q        <= MANUAL;
            pending_q      <= MODE_HBARS;
            fcnt_q         <= '0;
            key_q          <= MODE_HBARS;
            mode_changed_q <= 1'b0;
        end else begin
            vs1_q     <= vsync;
            vs2_q     <= vs1_q;
            vs3_q     <= vs2_q;
            state_q   <= state_d;
            pending_q <= pending_d;
            fcnt_q    <= fcnt_d;
            // Commit uses pending as it stood before this cycle's update.
            mode_changed_q <= frame_tick && (pending_q != key_q);
            if (frame_tick)
                key_q <= pending_q;
        end
    end

    assign key          = key_q;
    assign auto_on      = (state_q == AUTO);
    assign mode_changed = mode_changed_q;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Bench for vga_mode_ctrl: directed scenarios with literal expectations plus
// randomized button/vsync traffic compared every cycle against a behavioural model.
module tb_vga_mode_ctrl;
    localparam int D  = 4;
    localparam int AF = 3;

    logic       clk = 1'b0, rst = 1'b0;
    logic       btn_next = 1'b1, btn_prev = 1'b1, btn_auto = 1'b1, vsync = 1'b1;
    logic [1:0] key;
    logic       auto_on, mode_changed;

    int checks = 0, failures = 0, mc_cnt = 0, np_cnt = 0;

    vga_mode_ctrl #(.DEBOUNCE_CYCLES(D), .AUTO_FRAMES(AF)) dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
        .btn_auto(btn_auto), .vsync(vsync), .key(key), .auto_on(auto_on),
        .mode_changed(mode_changed));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: raw sample histories, mismatch run lengths, modular arithmetic.
    bit [7:0] rh [3];
    bit [7:0] vh;
    bit       db [3];
    int       run [3];
    bit       fell [3], pvis [3];
    int       m_pending, m_key, m_fcnt;
    bit       m_auto, m_mc;

    task automatic m_reset();
        for (int b = 0; b < 3; b++) begin
            rh[b] = 8'hFF; db[b] = 1'b1; run[b] = 0; fell[b] = 1'b0; pvis[b] = 1'b0;
        end
        vh = 8'hFF;
        m_pending = 0; m_key = 0; m_fcnt = 0; m_auto = 1'b0; m_mc = 1'b0;
    endtask

    task automatic m_step();
        bit raw [3];
        bit use_p [3];
        bit lvl, tick, fire;
        int delta, old_p;
        raw[0] = btn_next; raw[1] = btn_prev; raw[2] = btn_auto;
        for (int b = 0; b < 3; b++) begin
            use_p[b] = pvis[b];
            pvis[b]  = fell[b];
            fell[b]  = 1'b0;
            rh[b]    = {rh[b][6:0], raw[b]};
            lvl      = rh[b][2];
            if (lvl == db[b]) run[b] = 0;
            else begin
                run[b]++;
                if (run[b] == D) begin
                    run[b] = 0; db[b] = lvl; fell[b] = !lvl;
                end
            end
        end
        vh   = {vh[6:0], vsync};
        tick = vh[3] && !vh[2];
        fire = 1'b0;
        if (use_p[2]) begin
            m_auto = !m_auto; m_fcnt = 0;
        end else if (m_auto && tick) begin
            m_fcnt++;
            if (m_fcnt == AF) begin m_fcnt = 0; fire = 1'b1; end
        end
        delta = fire ? 1 : 0;
        if (use_p[0] || use_p[1]) begin
            m_fcnt = 0;
            delta  = (use_p[0] ? 1 : 0) - (use_p[1] ? 1 : 0);
        end
        old_p     = m_pending;
        m_pending = (m_pending + delta + 4) % 4;
        m_mc      = tick && (old_p != m_key);
        if (tick) m_key = old_p;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mode_changed) mc_cnt++;
            if (dut.u_next.press_o) np_cnt++;
            check("key", int'(key), m_key);
            check("auto_on", int'(auto_on), int'(m_auto));
            check("mode_changed", int'(mode_changed), int'(m_mc));
            check("pending", int'(dut.pending_q), m_pending);
            check("press_next", int'(dut.u_next.press_o), int'(pvis[0]));
            check("press_prev", int'(dut.u_prev.press_o), int'(pvis[1]));
            check("press_auto", int'(dut.u_auto.press_o), int'(pvis[2]));
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_reset();
        rst = 1'b0; tick_n(2); rst = 1'b1; tick_n(1);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_next = v;
            1: btn_prev = v;
            2: btn_auto = v;
            default: begin btn_next = v; btn_prev = v; end
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b0); tick_n(8); set_btn(b, 1'b1); tick_n(10);
    endtask

    task automatic vpulse();
        vsync = 1'b0; tick_n(3); vsync = 1'b1; tick_n(4);
    endtask

    initial begin : stim
        int at, mc0, np0;
        int exp_a [7];
        int exp_b [4];
        exp_a = '{0, 0, 0, 1, 1, 1, 2};
        exp_b = '{1, 1, 1, 2};

        tick_n(2);
        check("reset_key", int'(key), 0);
        check("reset_auto_on", int'(auto_on), 0);
        check("reset_mode_changed", int'(mode_changed), 0);
        rst = 1'b1; tick_n(1);

        // Held next: press pulse at cycle D+3, one commit on vsync.
        do_reset();
        at = -1; btn_next = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick_n(1);
            if (at < 0 && dut.u_next.press_o) at = k;
        end
        check("press_latency", at, 7);
        btn_next = 1'b1; tick_n(10);
        mc0 = mc_cnt;
        vpulse();
        check("commit_key", int'(key), 1);
        check("mode_changed_cycles", mc_cnt - mc0, 1);

        // Bounces shorter than the debounce window.
        do_reset();
        np0 = np_cnt;
        repeat (15) begin btn_next = ~btn_next; tick_n(2); end
        btn_next = 1'b1; tick_n(10);
        check("bounce_presses", np_cnt - np0, 0);
        check("bounce_pending", int'(dut.pending_q), 0);

        // prev wraps 0->3; four nexts return pending to 3 so the commit is silent.
        do_reset();
        press(1); vpulse();
        check("prev_wrap_key", int'(key), 3);
        mc0 = mc_cnt;
        repeat (4) press(0);
        check("four_next_pending", int'(dut.pending_q), 3);
        vpulse();
        check("equal_commit_key", int'(key), 3);
        check("equal_commit_no_pulse", mc_cnt - mc0, 0);

        // Auto cycle over 7 frames.
        do_reset();
        press(2);
        check("auto_on_after_press", int'(auto_on), 1);
        for (int i = 0; i < 7; i++) begin
            vpulse();
            check("auto_key", int'(key), exp_a[i]);
        end

        // Manual press at frame 2 restarts the auto interval.
        do_reset();
        press(2); vpulse(); vpulse(); press(0);
        for (int i = 0; i < 4; i++) begin
            vpulse();
            check("auto_delayed_key", int'(key), exp_b[i]);
        end

        // Simultaneous next+prev, then a press landing on the frame_tick cycle.
        do_reset();
        press(3);
        check("both_pending", int'(dut.pending_q), 0);
        btn_next = 1'b0; tick_n(5);
        vsync = 1'b0; tick_n(3);
        check("coincide_key", int'(key), 0);
        check("coincide_pending", int'(dut.pending_q), 1);
        vsync = 1'b1; btn_next = 1'b1; tick_n(10);
        vpulse();
        check("coincide_next_commit", int'(key), 1);

        // Reset mid-debounce while auto and key=2; held button debounces afresh.
        do_reset();
        press(2);
        repeat (7) vpulse();
        check("pre_reset_key", int'(key), 2);
        check("pre_reset_auto_on", int'(auto_on), 1);
        btn_prev = 1'b0; tick_n(3);
        rst = 1'b0; #1;
        check("async_reset_key", int'(key), 0);
        check("async_reset_auto_on", int'(auto_on), 0);
        check("async_reset_mode_changed", int'(mode_changed), 0);
        tick_n(2);
        rst = 1'b1; at = -1;
        for (int k = 1; k <= 15; k++) begin
            tick_n(1);
            if (at < 0 && dut.u_prev.press_o) at = k;
        end
        check("post_reset_press_latency", at, 7);
        btn_prev = 1'b1; tick_n(10);

        // Random traffic, checked every cycle by the model.
        do_reset();
        for (int s = 0; s < 350; s++) begin
            btn_next = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            btn_prev = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            btn_auto = ($urandom_range(0, 8) == 0) ? 1'b0 : 1'b1;
            vsync    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 120) == 0) begin
                rst = 1'b0; tick_n(1); rst = 1'b1;
            end
            tick_n(int'($urandom_range(1, 12)));
        end
        btn_next = 1'b1; btn_prev = 1'b1; btn_auto = 1'b1; vsync = 1'b1;
        tick_n(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
